// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: pointer-width computation and Gray/binary conversion.
// Functions work on 32-bit vectors; callers cast to their own pointer width.
package fifo_pkg;

    function automatic int calc_lw(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into the clk domain.
// Resets to zero so a freshly reset FIFO sees matching pointers on both sides.
module gray_ptr_sync #(
    parameter int W      = 5,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_chain [STAGES];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < STAGES; i++) begin
                r_chain[i] <= '0;
            end
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/async_fifo_lvl.sv
// Dual-clock show-ahead FIFO with Gray pointer CDC, fill levels and runtime almost-full/empty thresholds.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags; otherwise they read as 0.
module async_fifo_lvl
    import fifo_pkg::*;
#(
    parameter  int WIDTH       = 32,
    parameter  int DEPTH       = 16,
    parameter  int SYNC_STAGES = 2,
    localparam int LW          = calc_lw(DEPTH)
) (
    input  logic             clk1,
    input  logic             rstn,
    input  logic             clk2,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [LW-1:0]    af_thresh,
    output logic             full,
    output logic             almost_full,
    output logic [LW-1:0]    wr_level,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    input  logic [LW-1:0]    ae_thresh,
    output logic             empty,
    output logic             almost_empty,
    output logic [LW-1:0]    rd_level,
    output logic             wr_ovf,
    input  logic             wr_ovf_clr,
    output logic             rd_udf,
    input  logic             rd_udf_clr
);

    localparam int AW = LW - 1;

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [LW-1:0] r_wptr, r_wgray, r_wr_level;
    logic [LW-1:0] w_wptr_next, w_wgray_next, w_rsync, w_rsync_bin, w_wr_level_next;
    logic          r_full, w_full_next, w_wr_acc;

    logic [LW-1:0] r_rptr, r_rgray, r_rd_level;
    logic [LW-1:0] w_rptr_next, w_rgray_next, w_wsync, w_wsync_bin, w_rd_level_next;
    logic          r_empty, w_empty_next, w_rd_acc;

    gray_ptr_sync #(.W(LW), .STAGES(SYNC_STAGES)) u_sync_r2w (
        .clk  (clk1),
        .rstn (rstn),
        .i_d  (r_rgray),
        .o_q  (w_rsync)
    );

    gray_ptr_sync #(.W(LW), .STAGES(SYNC_STAGES)) u_sync_w2r (
        .clk  (clk2),
        .rstn (rstn),
        .i_d  (r_wgray),
        .o_q  (w_wsync)
    );

    // Write side (clk1)
    assign w_wr_acc        = wr_en & ~r_full;
    assign w_wptr_next     = r_wptr + LW'(w_wr_acc);
    assign w_wgray_next    = LW'(bin2gray(32'(w_wptr_next)));
    assign w_rsync_bin     = LW'(gray2bin(32'(w_rsync)));
    assign w_full_next     = (w_wgray_next == {~w_rsync[LW-1:LW-2], w_rsync[LW-3:0]});
    assign w_wr_level_next = w_wptr_next - w_rsync_bin;

    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            r_wptr     <= '0;
            r_wgray    <= '0;
            r_full     <= 1'b0;
            r_wr_level <= '0;
        end else begin
            r_wptr     <= w_wptr_next;
            r_wgray    <= w_wgray_next;
            r_full     <= w_full_next;
            r_wr_level <= w_wr_level_next;
        end
    end

    always_ff @(posedge clk1) begin
        if (w_wr_acc) begin
            r_mem[r_wptr[AW-1:0]] <= wr_data;
        end
    end

    // Read side (clk2)
    assign w_rd_acc        = rd_en & ~r_empty;
    assign w_rptr_next     = r_rptr + LW'(w_rd_acc);
    assign w_rgray_next    = LW'(bin2gray(32'(w_rptr_next)));
    assign w_wsync_bin     = LW'(gray2bin(32'(w_wsync)));
    assign w_empty_next    = (w_rgray_next == w_wsync);
    assign w_rd_level_next = w_wsync_bin - w_rptr_next;

    always_ff @(posedge clk2 or negedge rstn) begin
        if (!rstn) begin
            r_rptr     <= '0;
            r_rgray    <= '0;
            r_empty    <= 1'b1;
            r_rd_level <= '0;
        end else begin
            r_rptr     <= w_rptr_next;
            r_rgray    <= w_rgray_next;
            r_empty    <= w_empty_next;
            r_rd_level <= w_rd_level_next;
        end
    end

    assign rd_data  = r_mem[r_rptr[AW-1:0]];
    assign full     = r_full;
    assign wr_level = r_wr_level;
    assign empty    = r_empty;
    assign rd_level = r_rd_level;

    // Thresholds compare against the registered levels, so the flags update in the same
    // cycle as the levels and take their reset value from the threshold during reset.
    assign almost_full  = (r_wr_level >= af_thresh);
    assign almost_empty = (r_rd_level <= ae_thresh);

`ifdef FIFO_ERR_FLAGS_EN
    logic r_wr_ovf, r_rd_udf;

    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            r_wr_ovf <= 1'b0;
        end else if (wr_en & r_full) begin
            r_wr_ovf <= 1'b1;
        end else if (wr_ovf_clr) begin
            r_wr_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk2 or negedge rstn) begin
        if (!rstn) begin
            r_rd_udf <= 1'b0;
        end else if (rd_en & r_empty) begin
            r_rd_udf <= 1'b1;
        end else if (rd_udf_clr) begin
            r_rd_udf <= 1'b0;
        end
    end

    assign wr_ovf = r_wr_ovf;
    assign rd_udf = r_rd_udf;
`else
    logic w_unused_clr;
    assign w_unused_clr = wr_ovf_clr | rd_udf_clr;
    assign wr_ovf       = 1'b0;
    assign rd_udf       = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo_lvl.sv
// Self-checking bench for async_fifo_lvl: directed fill/drain/threshold/reset steps, then a
// randomized clock-ratio sweep scored against a queue model of FIFO contents.
module tb_async_fifo_lvl;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int SYNC  = 2;
    localparam int LW    = 5;
`ifdef FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic             clk1 = 1'b0, clk2 = 1'b0, rstn = 1'b1;
    logic             wr_en = 1'b0, rd_en = 1'b0, wr_ovf_clr = 1'b0, rd_udf_clr = 1'b0;
    logic [WIDTH-1:0] wr_data = '0, rd_data;
    logic [LW-1:0]    af_thresh = '0, ae_thresh = 5'd2, wr_level, rd_level;
    logic             full, almost_full, empty, almost_empty, wr_ovf, rd_udf;

    int checks = 0, failures = 0;
    int h2 = 162;
    int c2cnt = 0;
    logic [WIDTH-1:0] q[$];

    async_fifo_lvl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk1(clk1), .rstn(rstn), .clk2(clk2),
        .wr_en(wr_en), .wr_data(wr_data), .af_thresh(af_thresh),
        .full(full), .almost_full(almost_full), .wr_level(wr_level),
        .rd_en(rd_en), .rd_data(rd_data), .ae_thresh(ae_thresh),
        .empty(empty), .almost_empty(almost_empty), .rd_level(rd_level),
        .wr_ovf(wr_ovf), .wr_ovf_clr(wr_ovf_clr), .rd_udf(rd_udf), .rd_udf_clr(rd_udf_clr)
    );

    // clk1 edges fall on even times, clk2 on odd times while h2 is even, so they never coincide
    always #100 clk1 = ~clk1;
    initial begin
        #7;
        forever #(h2) clk2 = ~clk2;
    end
    always @(posedge clk2) c2cnt <= c2cnt + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rd_level(input int lvl, input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk2);
            if (int'(rd_level) == lvl) ok = 1'b1;
        end
        chk(tag, ok, 1);
    endtask

    task automatic wait_wr_level(input int lvl, input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk1);
            if (int'(wr_level) == lvl) ok = 1'b1;
        end
        chk(tag, ok, 1);
    endtask

    task automatic run_ratio(input int half2, input int n);
        int sent = 0, got = 0;
        h2 = half2;
        fork
            begin
                int cyc = 0;
                bit en;
                while (sent < n && cyc < n * 10) begin
                    @(negedge clk1);
                    cyc++;
                    chk("sw_wlvl_cons", int'(wr_level) >= q.size(), 1);
                    chk("sw_wlvl_max", int'(wr_level) <= DEPTH, 1);
                    en = ($urandom_range(0, 99) < 70);
                    wr_en   = en;
                    wr_data = $urandom;
                    if (en && !full) begin
                        q.push_back(wr_data);
                        sent++;
                    end
                end
                @(negedge clk1);
                wr_en = 1'b0;
            end
            begin
                int cyc = 0;
                bit en;
                logic [WIDTH-1:0] exp;
                while (got < n && cyc < n * 20) begin
                    @(negedge clk2);
                    cyc++;
                    chk("sw_rlvl_cons", int'(rd_level) <= q.size(), 1);
                    chk("sw_rlvl_max", int'(rd_level) <= DEPTH, 1);
                    en = ($urandom_range(0, 99) < 70);
                    if (!empty) begin
                        chk("sw_model_nonempty", q.size() > 0, 1);
                        if (en && q.size() > 0) begin
                            exp = q.pop_front();
                            chk("sw_data", rd_data, exp);
                            got++;
                        end
                    end
                    rd_en = en;
                end
                @(negedge clk2);
                rd_en = 1'b0;
            end
        join
        chk("sw_sent", sent, n);
        chk("sw_got", got, n);
        chk("sw_model_drained", q.size(), 0);
    endtask

    initial begin
        int c0;
        bit ok;

        // Reset with af_thresh=0 so almost_full must be 1 while levels are 0
        #5 rstn = 1'b0;
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_almost_empty", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_almost_full_af0", almost_full, 1);
        chk("rst_wr_level", wr_level, 0);
        chk("rst_rd_level", rd_level, 0);
        chk("rst_wr_ovf", wr_ovf, 0);
        chk("rst_rd_udf", rd_udf, 0);
        af_thresh = 5'd12;
        #1;
        chk("rst_almost_full_af12", almost_full, 0);
        @(negedge clk1);
        rstn = 1'b1;
        repeat (2) @(negedge clk1);

        // Fill 0..15 with no reads
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk1);
            if (i > 0) begin
                chk("fill_wr_level", wr_level, i);
                chk("fill_almost_full", almost_full, i >= 12);
                chk("fill_full", full, 0);
            end
            wr_en   = 1'b1;
            wr_data = i;
        end
        @(negedge clk1);
        chk("fill16_full", full, 1);
        chk("fill16_wr_level", wr_level, DEPTH);
        chk("fill16_almost_full", almost_full, 1);
        chk("fill16_wr_ovf", wr_ovf, 0);
        wr_data = 32'd99;
        @(negedge clk1);
        chk("ovf_wr_level", wr_level, DEPTH);
        chk("ovf_full", full, 1);
        chk("ovf_set", wr_ovf, ERR_EN);
        wr_ovf_clr = 1'b1;
        @(negedge clk1);
        chk("ovf_set_wins", wr_ovf, ERR_EN);
        wr_en = 1'b0;
        @(negedge clk1);
        wr_ovf_clr = 1'b0;
        chk("ovf_cleared", wr_ovf, 0);

        // Drain with ae_thresh=3
        ae_thresh = 5'd3;
        wait_rd_level(DEPTH, "drain_rd_level16");
        chk("drain_not_empty", empty, 0);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_data", rd_data, i);
            chk("drain_rd_level", rd_level, DEPTH - i);
            chk("drain_almost_empty", almost_empty, (DEPTH - i) <= 3);
            rd_en = 1'b1;
            @(negedge clk2);
        end
        rd_en = 1'b0;
        chk("drained_empty", empty, 1);
        chk("drained_rd_level", rd_level, 0);
        chk("drained_almost_empty", almost_empty, 1);

        // Underflow flag
        rd_en = 1'b1;
        @(negedge clk2);
        chk("udf_set", rd_udf, ERR_EN);
        chk("udf_empty", empty, 1);
        chk("udf_rd_level", rd_level, 0);
        rd_udf_clr = 1'b1;
        @(negedge clk2);
        chk("udf_set_wins", rd_udf, ERR_EN);
        rd_en = 1'b0;
        @(negedge clk2);
        rd_udf_clr = 1'b0;
        chk("udf_cleared", rd_udf, 0);

        wait_wr_level(0, "wr_side_drained");
        chk("wr_side_not_full", full, 0);
        chk("wr_side_almost_full", almost_full, 0);

        // Push-to-not-empty latency in clk2 edges
        @(negedge clk1);
        wr_en   = 1'b1;
        wr_data = 32'hA5A5_0001;
        @(posedge clk1);
        c0 = c2cnt;
        @(negedge clk1);
        wr_en = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk2);
            if (!empty) ok = 1'b1;
        end
        chk("lat_seen", ok, 1);
        chk("lat_edges", c2cnt - c0, SYNC + 1);
        chk("lat_data", rd_data, 32'hA5A5_0001);
        rd_en = 1'b1;
        @(negedge clk2);
        rd_en = 1'b0;
        chk("lat_pop_empty", empty, 1);
        wait_wr_level(0, "lat_wr_drained");

        // Mid-stream reset with 7 entries
        for (int i = 0; i < 7; i++) begin
            @(negedge clk1);
            wr_en   = 1'b1;
            wr_data = 100 + i;
        end
        @(negedge clk1);
        wr_en = 1'b0;
        wait_rd_level(7, "mid_rd_level7");
        @(negedge clk1);
        #3 rstn = 1'b0;
        #1;
        chk("mid_empty", empty, 1);
        chk("mid_full", full, 0);
        chk("mid_wr_level", wr_level, 0);
        chk("mid_rd_level", rd_level, 0);
        chk("mid_almost_empty", almost_empty, 1);
        chk("mid_almost_full", almost_full, 0);
        chk("mid_wr_ovf", wr_ovf, 0);
        chk("mid_rd_udf", rd_udf, 0);
        repeat (2) @(negedge clk1);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk1);
            wr_en   = 1'b1;
            wr_data = 200 + i;
        end
        @(negedge clk1);
        wr_en = 1'b0;
        wait_rd_level(3, "post_rst_rd_level3");
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_data", rd_data, 200 + i);
            rd_en = 1'b1;
            @(negedge clk2);
        end
        rd_en = 1'b0;
        chk("post_rst_empty", empty, 1);

        // Random traffic at clk2/clk1 ratios of about 0.3, 1.0 and 3.7
        run_ratio(334, 3400);
        run_ratio(100, 3400);
        run_ratio(27, 3400);

        repeat (20) @(negedge clk1);
        chk("final_empty", empty, 1);
        chk("final_full", full, 0);
        chk("final_wr_level", wr_level, 0);
        chk("final_rd_level", rd_level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
